// File: rtl/factorial_accel.sv
// factorial_accel: iterative n! coprocessor for the MIPS SoC.
// It does one full-width multiply per cycle, counting down from n, and
// keeps a sticky overflow bit so the caller can tell when n! no longer
// fits in DATA_W bits. It talks to the processor through a start pulse
// and a level done flag.
module factorial_accel #(
  parameter int N_W    = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [N_W-1:0]    n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] result
);

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] acc, acc_next;
  logic [N_W-1:0]    cnt, cnt_next;
  logic              ovf, ovf_next;
  logic              done_next, error_next;
  logic [DATA_W-1:0] result_next;
  logic [2*DATA_W-1:0] prod;

  // Double-width product. Any set bit in the upper half means the
  // running factorial no longer fits in DATA_W bits.
  assign prod = {{DATA_W{1'b0}}, acc} * {{(2*DATA_W-N_W){1'b0}}, cnt};

  // busy is decoded from the state register, so it is still a registered output.
  assign busy = (state == MUL);

  // State and datapath registers. Reset leaves acc at 1, the identity for the product.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      acc    <= DATA_W'(1);
      cnt    <= '0;
      ovf    <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_next;
      acc    <= acc_next;
      cnt    <= cnt_next;
      ovf    <= ovf_next;
      done   <= done_next;
      error  <= error_next;
      result <= result_next;
    end
  end

  // Next-state and datapath logic. Every register holds its value unless a transition changes it.
  always_comb begin
    state_next  = state;
    acc_next    = acc;
    cnt_next    = cnt;
    ovf_next    = ovf;
    done_next   = done;
    error_next  = error;
    result_next = result;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = MUL;
          acc_next   = DATA_W'(1);
          cnt_next   = n;
          ovf_next   = 1'b0;
          done_next  = 1'b0;
          error_next = 1'b0;
        end
      end
      MUL: begin
        if (cnt > N_W'(1)) begin
          acc_next = prod[DATA_W-1:0];
          ovf_next = ovf | (|prod[2*DATA_W-1:DATA_W]);
          cnt_next = cnt - N_W'(1);
        end else begin
          result_next = ovf ? {DATA_W{1'b1}} : acc;
          error_next  = ovf;
          done_next   = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_factorial_accel.sv
// Self-checking bench for factorial_accel. It applies a table of operands
// with known factorials, then runs hand-written sequences for the done hold,
// busy protection and asynchronous reset. Expected results go into a
// scoreboard queue when a start is driven. They are popped and compared
// when done rises.
module tb_factorial_accel;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [4:0]  n;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] result;

  typedef struct {
    int          nv;
    logic [31:0] res;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];
  int   compared;
  int   mismatched;

  factorial_accel #(.N_W(5), .DATA_W(32)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .n      (n),
    .busy   (busy),
    .done   (done),
    .error  (error),
    .result (result)
  );

  // Free-running clock: rising edges at 5, 15, 25 ns and so on.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one value against its expected value and count the result.
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive a one-cycle start pulse from a falling edge and queue the expected outcome.
  // On return we are at the falling edge after the accepted start edge (edge 0).
  task automatic applyStimulus(input int nv, input logic [31:0] res, input logic err);
    exp_t e;
    e.res = res;
    e.err = err;
    e.lat = (nv < 1) ? 1 : nv;
    @(negedge clk);
    start = 1'b1;
    n     = 5'(nv);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    n     = 5'($urandom_range(0, 31));
  endtask

  // Count the edges after edge 0 until done is seen, within a bounded budget.
  // busy must stay high until done rises.
  task automatic waitDone(input string name, output int lat);
    lat = 0;
    while (!done && lat < 64) begin
      check({name, " busy while computing"}, 64'(busy), 64'd1);
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s timeout: done not seen within %0d cycles", name, lat);
    end
  endtask

  // Pop the oldest expectation and compare it with the finished operation.
  task automatic checkOutput(input string name, input int lat);
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s scoreboard: queue empty", name);
    end else begin
      e = sb.pop_front();
      check({name, " result"},  64'(result), 64'(e.res));
      check({name, " error"},   64'(error),  64'(e.err));
      check({name, " latency"}, 64'(lat),    64'(e.lat));
      check({name, " done"},    64'(done),   64'd1);
      check({name, " busy low"}, 64'(busy),  64'd0);
    end
  endtask

  initial begin
    int lat;
    string nm;
    compared   = 0;
    mismatched = 0;

    vecs[0]  = '{nv: 0,  res: 32'h0000_0001, err: 1'b0};
    vecs[1]  = '{nv: 1,  res: 32'h0000_0001, err: 1'b0};
    vecs[2]  = '{nv: 2,  res: 32'h0000_0002, err: 1'b0};
    vecs[3]  = '{nv: 3,  res: 32'h0000_0006, err: 1'b0};
    vecs[4]  = '{nv: 5,  res: 32'h0000_0078, err: 1'b0};
    vecs[5]  = '{nv: 7,  res: 32'd5040,      err: 1'b0};
    vecs[6]  = '{nv: 10, res: 32'd3628800,   err: 1'b0};
    vecs[7]  = '{nv: 12, res: 32'h1C8C_FC00, err: 1'b0};
    vecs[8]  = '{nv: 13, res: 32'hFFFF_FFFF, err: 1'b1};
    vecs[9]  = '{nv: 20, res: 32'hFFFF_FFFF, err: 1'b1};
    vecs[10] = '{nv: 31, res: 32'hFFFF_FFFF, err: 1'b1};

    reset_n = 1'b0;
    start   = 1'b0;
    n       = '0;
    #22;
    check("reset busy",   64'(busy),   64'd0);
    check("reset done",   64'(done),   64'd0);
    check("reset error",  64'(error),  64'd0);
    check("reset result", 64'(result), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic n=5: done must stay high and result must hold for 10 idle cycles.
    applyStimulus(5, 32'd120, 1'b0);
    check("basic done cleared", 64'(done), 64'd0);
    waitDone("basic", lat);
    checkOutput("basic", lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("basic done hold",   64'(done),   64'd1);
      check("basic result hold", 64'(result), 64'd120);
    end

    // Table of operands, including the edge and overflow cases.
    for (int i = 0; i < 11; i++) begin
      nm = $sformatf("vec n=%0d", vecs[i].nv);
      applyStimulus(vecs[i].nv, vecs[i].res, vecs[i].err);
      check({nm, " busy after start"}, 64'(busy), 64'd1);
      check({nm, " done cleared"},     64'(done), 64'd0);
      check({nm, " error cleared"},    64'(error), 64'd0);
      waitDone(nm, lat);
      checkOutput(nm, lat);
    end

    // Busy protection: a start pulse during the computation must be ignored.
    applyStimulus(6, 32'd720, 1'b0);
    lat = 0;
    repeat (2) begin
      @(negedge clk);
      lat++;
    end
    start = 1'b1;
    n     = 5'd3;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (!done && lat < 64) begin
      check("protect busy", 64'(busy), 64'd1);
      @(negedge clk);
      lat++;
    end
    checkOutput("protect n=6", lat);
    @(negedge clk);
    check("protect no restart", 64'(busy), 64'd0);

    // Starting n=3 clears done on the start edge. result keeps 720 until n=3 completes.
    applyStimulus(3, 32'd6, 1'b0);
    check("restart done cleared", 64'(done),   64'd0);
    check("restart result held",  64'(result), 64'd720);
    @(negedge clk);
    check("restart result held2", 64'(result), 64'd720);
    lat = 1;
    while (!done && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("restart n=3", lat);

    // Async reset during n=10. Outputs must clear between edges.
    applyStimulus(10, 32'd3628800, 1'b0);
    repeat (4) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async busy",   64'(busy),   64'd0);
    check("async done",   64'(done),   64'd0);
    check("async error",  64'(error),  64'd0);
    check("async result", 64'(result), 64'd0);
    if (sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
    @(negedge clk);
    check("reset hold busy", 64'(busy), 64'd0);
    reset_n = 1'b1;

    applyStimulus(4, 32'd24, 1'b0);
    waitDone("post-reset n=4", lat);
    checkOutput("post-reset n=4", lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
